bcd2bin_seq: RTL and testbench
==============================

BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 Parameter: DIGITS, default 5, number of BCD input digits (SHALL be >= 1).
REQ-002 Parameter: W, default 16, binary output width (SHALL be >= 4).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: in_valid  input  1  BCD word present on bcd.
REQ-006 Port: in_ready  output  1  block accepts a new word.
REQ-007 Port: bcd  input  4*DIGITS  packed BCD; bcd[3:0] is the ones digit, bcd[4*DIGITS-1 -: 4] is the most significant digit.
REQ-008 Port: out_valid  output  1  result present on bin/ovf/err.
REQ-009 Port: out_ready  input  1  consumer accepts result.
REQ-010 Port: bin  output  W  unsigned binary value of bcd.
REQ-011 Port: ovf  output  1  decimal value exceeded 2^W-1; bin saturated.
REQ-012 Port: err  output  1  at least one input digit > 9 (see Configuration).

Function
REQ-013 Three states SHALL exist: IDLE, CONV, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE with in_valid=1: latch bcd, clear accumulator, ovf and err, set digit index to DIGITS-1, go to CONV.
REQ-016 CONV, each cycle: acc <= acc*10 + digit[index], with acc*10 formed as (acc<<3)+(acc<<1) in a W+4-bit datapath; index decrements.
REQ-017 CONV SHALL leave for DONE on the cycle that processes digit index 0; out_valid SHALL rise exactly DIGITS cycles after the accepting edge.
REQ-018 If any step result exceeds 2^W-1: ovf SHALL set and stay set; acc SHALL hold 2^W-1 for the remaining steps.
REQ-019 bin SHALL equal acc[W-1:0] in DONE; bin/ovf/err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 DONE with out_ready=1: go to IDLE; next accept possible on the following cycle (minimum initiation interval DIGITS+2 cycles).
REQ-021 in_valid in CONV or DONE SHALL be ignored; bcd SHALL be sampled only at the accepting edge.
REQ-022 bcd=0 SHALL yield bin=0, ovf=0 after the full DIGITS-cycle latency (no early exit).

Reset
REQ-023 rst=1 SHALL asynchronously force state IDLE, acc=0, index=DIGITS-1, bin=0, ovf=0, err=0, out_valid=0; in_ready SHALL be 1 from the first clock edge after rst deasserts.
REQ-024 rst asserted during CONV or DONE SHALL discard the in-flight conversion; no out_valid pulse SHALL follow.

Configuration
REQ-025 Macro BCD2BIN_DIGCHK_EN defined: err SHALL set in CONV when the processed digit > 9, stay set through DONE, and the digit SHALL still be accumulated at its binary weight (0xA adds 10).
REQ-026 Macro BCD2BIN_DIGCHK_EN undefined: err SHALL be tied to 0, no digit-check logic built; digits > 9 accumulate at binary weight.

Verification (DIGITS=5, W=16)
REQ-027 bcd=0x12345 accepted -> out_valid 5 cycles later, bin=0x3039, ovf=0, err=0.
REQ-028 bcd=0x65535 -> bin=0xFFFF, ovf=0; bcd=0x65536 -> bin=0xFFFF, ovf=1; bcd=0x99999 -> bin=0xFFFF, ovf=1.
REQ-029 out_ready held 0 for 3 cycles after out_valid with bcd=0x00042 -> bin=0x002A stable all 3 cycles, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-030 rst pulsed on 2nd CONV cycle of bcd=0x54321 -> out_valid never asserts, outputs 0, in_ready=1 after release; next bcd=0x00007 -> bin=0x0007.
REQ-031 With BCD2BIN_DIGCHK_EN, bcd=0x1A000 -> err=1, bin=20000 (0x4E20); without macro -> err=0, bin=0x4E20.
REQ-032 Back-to-back words 0x00001, 0x00002 with in_valid and out_ready held 1 -> two results 0x0001, 0x0002, accepts spaced 7 cycles apart.

Source files
------------

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential packed-BCD to unsigned-binary converter.
// One digit is folded in per cycle, most significant digit first, using
// acc = acc*10 + digit. The result saturates at 2^W-1 and flags ovf.
// Handshake: valid/ready on both the input and the output side.
// Optional feature macro: BCD2BIN_DIGCHK_EN. When it is defined, err flags
// any digit > 9. Such a digit is still accumulated at its binary weight.
`timescale 1ns/1ps

module bcd2bin_seq #(
  parameter int DIGITS = 5,
  parameter int W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] bcd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        bin,
  output logic                ovf,
  output logic                err
);

  localparam int               IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);
  localparam logic [W+3:0]     SAT     = {4'b0000, {W{1'b1}}};

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [W-1:0]        acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                ovf_q, ovf_d;
  logic [3:0]          digit;
  logic [W+3:0]        acc_ext;
  logic [W+3:0]        step;
`ifdef BCD2BIN_DIGCHK_EN
  logic                err_q, err_d;
`endif

  // Select the digit at the current index and form acc*10 + digit.
  // The datapath is 4 bits wider than acc, so the worst case cannot wrap.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) digit = bcd_q[4*i +: 4];
    end
    acc_ext = {4'b0000, acc_q};
    step    = (acc_ext << 3) + (acc_ext << 1) + {{W{1'b0}}, digit};
  end

  // Next-state and datapath update for the IDLE/CONV/DONE controller.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
`ifdef BCD2BIN_DIGCHK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bcd_d   = bcd;
          acc_d   = '0;
          ovf_d   = 1'b0;
`ifdef BCD2BIN_DIGCHK_EN
          err_d   = 1'b0;
`endif
          idx_d   = IDX_TOP;
          state_d = CONV;
        end
      end
      CONV: begin
        // Once saturated, hold 2^W-1 for every remaining digit.
        if (ovf_q || (step > SAT)) begin
          acc_d = '1;
          ovf_d = 1'b1;
        end else begin
          acc_d = step[W-1:0];
        end
`ifdef BCD2BIN_DIGCHK_EN
        if (digit > 4'd9) err_d = 1'b1;
`endif
        if (idx_q == '0) begin
          idx_d   = IDX_TOP;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset is asynchronous and drops any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      acc_q   <= '0;
      idx_q   <= IDX_TOP;
      ovf_q   <= 1'b0;
`ifdef BCD2BIN_DIGCHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
`ifdef BCD2BIN_DIGCHK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bin       = acc_q;
  assign ovf       = ovf_q;
`ifdef BCD2BIN_DIGCHK_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq (DIGITS=5, W=16).
// It applies a table of directed vectors, then hand-written sequences for
// output stall, reset mid-conversion and back-to-back accepts.
`timescale 1ns/1ps

module tb_bcd2bin_seq;

  localparam int DIGITS = 5;
  localparam int W      = 16;
`ifdef BCD2BIN_DIGCHK_EN
  localparam logic DIGCHK = 1'b1;
`else
  localparam logic DIGCHK = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [W-1:0]        bin;
  logic                ovf;
  logic                err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [19:0] bcd;
    logic [15:0] bin;
    logic        ovf;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  bcd2bin_seq #(.DIGITS(DIGITS), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd       (bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin       (bin),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge while the DUT is in IDLE. Returns at the negedge
  // where out_valid is seen (or when the bound expires). lat counts edges
  // after the accepting edge.
  task automatic convert(input logic [19:0] b, output int lat);
    in_valid = 1'b1;
    bcd      = b;
    @(negedge clk);
    in_valid = 1'b0;
    bcd      = 20'hFFFFF;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    int          hits;
    int          cyc;
    int          n_acc;
    int          n_res;
    int          acc_cyc[2];
    logic [15:0] res[2];
    logic [19:0] words[2];

    vecs[0]  = '{20'h12345, 16'h3039, 1'b0, 1'b0};
    vecs[1]  = '{20'h65535, 16'hFFFF, 1'b0, 1'b0};
    vecs[2]  = '{20'h65536, 16'hFFFF, 1'b1, 1'b0};
    vecs[3]  = '{20'h99999, 16'hFFFF, 1'b1, 1'b0};
    vecs[4]  = '{20'h00000, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{20'h00042, 16'h002A, 1'b0, 1'b0};
    vecs[6]  = '{20'h1A000, 16'h4E20, 1'b0, DIGCHK};
    vecs[7]  = '{20'h00099, 16'h0063, 1'b0, 1'b0};
    vecs[8]  = '{20'h70000, 16'hFFFF, 1'b1, 1'b0};
    vecs[9]  = '{20'h06553, 16'h1999, 1'b0, 1'b0};
    vecs[10] = '{20'h0000F, 16'h000F, 1'b0, DIGCHK};
    vecs[11] = '{20'h00001, 16'h0001, 1'b0, 1'b0};

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bin", 32'(bin), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      convert(vecs[i].bcd, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(DIGITS));
      check($sformatf("v%0d_bin", i), 32'(bin), 32'(vecs[i].bin));
      check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
      release_result();
    end

    // Output stall: result held for 3 cycles, in_valid ignored meanwhile
    convert(20'h00042, lat);
    check("stall_latency", 32'(lat), 32'(DIGITS));
    in_valid = 1'b1;
    bcd      = 20'h99999;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d_bin", k), 32'(bin), 32'h002A);
      check($sformatf("stall%0d_out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_exit_out_valid", 32'(out_valid), 32'd0);
    check("stall_exit_in_ready", 32'(in_ready), 32'd1);

    // Reset during the second CONV cycle discards the conversion
    in_valid = 1'b1;
    bcd      = 20'h54321;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_bin", 32'(bin), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    hits = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    check("midrst_no_out_valid", 32'(hits), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    convert(20'h00007, lat);
    check("midrst_next_latency", 32'(lat), 32'(DIGITS));
    check("midrst_next_bin", 32'(bin), 32'h0007);
    release_result();

    // Back-to-back accepts with out_ready held high
    words[0]  = 20'h00001;
    words[1]  = 20'h00002;
    n_acc     = 0;
    n_res     = 0;
    cyc       = 0;
    acc_cyc   = '{0, 0};
    res       = '{16'h0, 16'h0};
    out_ready = 1'b1;
    while (n_res < 2 && cyc < 40) begin
      if (out_valid) begin
        res[n_res] = bin;
        n_res++;
      end
      if (n_acc < 2) begin
        in_valid = 1'b1;
        if (in_ready) begin
          bcd          = words[n_acc];
          acc_cyc[n_acc] = cyc;
          n_acc++;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_results", 32'(n_res), 32'd2);
    check("b2b_res0", 32'(res[0]), 32'h0001);
    check("b2b_res1", 32'(res[1]), 32'h0002);
    check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(DIGITS + 2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
